// File: rtl/vcpu_ctrl_pkg.sv
// Shared types and default parameters for the vector CPU run controller.
package vcpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CPU,
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int unsigned DEF_CNT_W        = 32;
    localparam int unsigned DEF_RST_CYCLES   = 2;
    localparam int unsigned DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/vcpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value the
// counter would take if enabled this cycle.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_inc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_inc = (count_q == '1) ? count_q : count_q + W'(1);
        count_d   = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vcpu_run_ctrl.sv
// Run controller: resets and starts the vector CPU, waits for EndFlag plus a
// drain window, and reports done. Optional watchdog: RUN_CTRL_WATCHDOG_EN.
module vcpu_run_ctrl
    import vcpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             EndFlag,
    input  logic             COMFlag,
    output logic             cpu_reset,
    output logic             cpu_start,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] com_count
);

    // One down-counter serves both RESET_CPU and DRAIN; it holds "cycles left - 1".
    localparam int unsigned TMR_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    run_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             com_prev_q, com_prev_d;

    logic             cyc_clr, cyc_en;
    logic             com_clr, com_en;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] com_inc_unused;
    logic             wd_hit;

`ifdef RUN_CTRL_WATCHDOG_EN
    assign wd_hit = (cfg_timeout != '0) && (cyc_inc == cfg_timeout);
`else
    logic wd_inputs_unused;
    assign wd_inputs_unused = ^{cfg_timeout, cyc_inc};
    assign wd_hit           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        com_prev_d = com_prev_q;
        cyc_clr    = 1'b0;
        cyc_en     = 1'b0;
        com_clr    = 1'b0;
        com_en     = 1'b0;

        case (state_q)
            IDLE, DONE, TIMEOUT: begin
                if (go) begin
                    state_d    = RESET_CPU;
                    tmr_d      = TMR_W'(RST_CYCLES - 1);
                    cyc_clr    = 1'b1;
                    com_clr    = 1'b1;
                    com_prev_d = 1'b0;
                end
            end
            RESET_CPU: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                cyc_en     = 1'b1;
                com_en     = COMFlag && !com_prev_q;
                com_prev_d = COMFlag;
                if (abort) begin
                    state_d = IDLE;
                end else if (EndFlag) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        tmr_d   = TMR_W'(DRAIN_CYCLES - 1);
                    end
                end else if (wd_hit) begin
                    state_d = TIMEOUT;
                end
            end
            DRAIN: begin
                com_en     = COMFlag && !com_prev_q;
                com_prev_d = COMFlag;
                if (abort) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            com_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            com_prev_q <= com_prev_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (cyc_clr),
        .en        (cyc_en),
        .count     (cycle_count),
        .count_inc (cyc_inc)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_com_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (com_clr),
        .en        (com_en),
        .count     (com_count),
        .count_inc (com_inc_unused)
    );

    assign cpu_reset = (state_q == IDLE) || (state_q == RESET_CPU);
    assign cpu_start = (state_q == RUN) || (state_q == DRAIN);
    assign busy      = (state_q == RESET_CPU) || (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
`ifdef RUN_CTRL_WATCHDOG_EN
    assign timed_out = (state_q == TIMEOUT);
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_vcpu_run_ctrl.sv
// Self-checking bench for vcpu_run_ctrl: timestamp-based reference model
// compared every cycle, plus directed scenario checks with literal values.
module tb_vcpu_run_ctrl;

    localparam int unsigned CW   = 32;
    localparam int unsigned RSTC = 2;
    localparam int unsigned DRC  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          EndFlag = 1'b0;
    logic          COMFlag = 1'b0;
    logic [CW-1:0] cfg_timeout = '0;
    logic          cpu_reset, cpu_start, busy, done, timed_out;
    logic [CW-1:0] cycle_count, com_count;

    always #5 clk = ~clk;

    vcpu_run_ctrl #(
        .CNT_W        (CW),
        .RST_CYCLES   (RSTC),
        .DRAIN_CYCLES (DRC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .abort       (abort),
        .cfg_timeout (cfg_timeout),
        .EndFlag     (EndFlag),
        .COMFlag     (COMFlag),
        .cpu_reset   (cpu_reset),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count),
        .com_count   (com_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode label plus the edge index at which the current
    // timed phase began; phase ends are found by edge arithmetic.
    localparam int M_IDLE = 0, M_RST = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4, M_TO = 5;
    int            m_mode = M_IDLE;
    longint        n_edge = 0;
    longint        t_mark = 0;
    logic [CW-1:0] m_cyc  = '0;
    logic [CW-1:0] m_com  = '0;
    logic          m_prev = 1'b0;

    always @(posedge clk) begin
        n_edge++;
        if (!reset) begin
            m_mode = M_IDLE;
            m_cyc  = '0;
            m_com  = '0;
            m_prev = 1'b0;
        end else begin
            if (m_mode == M_RUN || m_mode == M_DRAIN) begin
                if (COMFlag && !m_prev && m_com != {CW{1'b1}}) m_com = m_com + 1;
                m_prev = COMFlag;
            end
            if (m_mode == M_RUN && m_cyc != {CW{1'b1}}) m_cyc = m_cyc + 1;

            if (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_TO) begin
                if (go) begin
                    m_mode = M_RST;
                    t_mark = n_edge;
                    m_cyc  = '0;
                    m_com  = '0;
                    m_prev = 1'b0;
                end
            end else if (abort) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_RST) begin
                if (n_edge == t_mark + RSTC) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (EndFlag) begin
                    t_mark = n_edge;
                    m_mode = (DRC == 0) ? M_DONE : M_DRAIN;
                end
`ifdef RUN_CTRL_WATCHDOG_EN
                else if (cfg_timeout != 0 && m_cyc == cfg_timeout) begin
                    m_mode = M_TO;
                end
`endif
            end else if (m_mode == M_DRAIN) begin
                if (n_edge == t_mark + DRC) m_mode = M_DONE;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cpu_reset", cpu_reset, (m_mode == M_IDLE || m_mode == M_RST));
            chk("m_cpu_start", cpu_start, (m_mode == M_RUN || m_mode == M_DRAIN));
            chk("m_busy", busy, (m_mode == M_RST || m_mode == M_RUN || m_mode == M_DRAIN));
            chk("m_done", done, (m_mode == M_DONE));
            chk("m_timed_out", timed_out, (m_mode == M_TO));
            chk("m_cycle_count", cycle_count, m_cyc);
            chk("m_com_count", com_count, m_com);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Power-on reset held 3 cycles
        step();
        chk_en = 1'b1;
        step(2);
        reset = 1'b1;
        step();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_com", com_count, 0);

        // Nominal run: EndFlag on the 10th RUN cycle
        launch();
        chk("go_busy", busy, 1);
        chk("go_cpu_reset", cpu_reset, 1);
        chk("go_start_t1", cpu_start, 0);
        step();
        chk("go_start_t2", cpu_start, 0);
        step();
        chk("go_start_t3", cpu_start, 1);
        chk("go_reset_t3", cpu_reset, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) EndFlag = 1'b1;
            step();
        end
        EndFlag = 1'b0;
        chk("end_cycle", cycle_count, 10);
        chk("end_busy", busy, 1);
        chk("end_done", done, 0);
        step(3);
        chk("drain_done_early", done, 0);
        step();
        chk("drain_done", done, 1);
        chk("drain_busy", busy, 0);
        chk("done_cpu_start", cpu_start, 0);
        chk("done_cpu_reset", cpu_reset, 0);
        chk("done_cycle", cycle_count, 10);
        chk("done_com", com_count, 0);

        // go in DONE restarts; COMFlag edges; go in RUN ignored
        launch();
        chk("rego_cycle", cycle_count, 0);
        chk("rego_com", com_count, 0);
        chk("rego_done", done, 0);
        chk("rego_busy", busy, 1);
        step(2);
        for (int p = 0; p < 3; p++) begin
            COMFlag = 1'b1;
            step();
            COMFlag = 1'b0;
            step(2);
        end
        launch();
        chk("go_in_run_busy", busy, 1);
        chk("go_in_run_start", cpu_start, 1);
        COMFlag = 1'b1;
        step(4);
        COMFlag = 1'b0;
        step();
        EndFlag = 1'b1;
        step();
        EndFlag = 1'b0;
        chk("run2_cycle", cycle_count, 16);
        step(4);
        chk("run2_done", done, 1);
        chk("run2_com", com_count, 4);

        // abort wins over EndFlag in the same cycle
        launch();
        step(2);
        step(3);
        abort   = 1'b1;
        EndFlag = 1'b1;
        step();
        abort   = 1'b0;
        EndFlag = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_done", done, 0);
        chk("abort_cpu_start", cpu_start, 0);
        step(5);
        chk("abort_no_done", done, 0);

        // abort during RESET_CPU
        launch();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_cpu_reset", cpu_reset, 1);
        step(3);
        chk("abort_rst_stays", cpu_start, 0);

        // Watchdog
        cfg_timeout = 7;
        launch();
`ifdef RUN_CTRL_WATCHDOG_EN
        for (int i = 0; i < 50 && !timed_out; i++) step();
        chk("wd_timed_out", timed_out, 1);
        chk("wd_cycle", cycle_count, 7);
        chk("wd_cpu_start", cpu_start, 0);
        chk("wd_busy", busy, 0);
        cfg_timeout = 0;
        launch();
        step(2 + 30);
        chk("wd0_busy", busy, 1);
        chk("wd0_timed_out", timed_out, 0);
        chk("wd0_cycle", cycle_count, 30);
`else
        step(2 + 20);
        chk("nowd_busy", busy, 1);
        chk("nowd_timed_out", timed_out, 0);
        chk("nowd_cycle", cycle_count, 20);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("wd_abort_busy", busy, 0);

        // Reset mid-run
        launch();
        step(5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_cycle", cycle_count, 0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
